// File: rtl/gds_pkg.sv
// Shared definitions for the garage-door-sensor serial link (transmitter and receiver).
package gds_pkg;

  // Frame state encoding shared with the receiver.
  typedef enum logic [2:0] {
    GDS_IDLE = 3'd0,
    GDS_PRE  = 3'd1,
    GDS_DATA = 3'd2,
    GDS_PAR  = 3'd3,
    GDS_STOP = 3'd4
  } gds_state_e;

  localparam int                    GDS_PRE_W    = 4;
  localparam logic [GDS_PRE_W-1:0]  GDS_PREAMBLE = 4'b1110;
  localparam int                    GDS_CODE_W   = 3;

  // Even parity bit over a code: 1 when the code has an odd number of ones.
  function automatic logic even_parity(input logic [31:0] v);
    return ^v;
  endfunction

endpackage

// File: rtl/gds_bit_timer.sv
// Bit-period timer: bit_end is high on the last clk cycle of each line bit.
// restart realigns the period so the cycle after restart is cycle 0 of a new bit.
module gds_bit_timer #(
  parameter int BIT_CYCLES = 1
) (
  input  logic clk,
  input  logic arst_n,
  input  logic restart,
  output logic bit_end
);

  localparam int             CYC_W    = (BIT_CYCLES > 1) ? $clog2(BIT_CYCLES) : 1;
  localparam logic [CYC_W-1:0] CYC_LAST = CYC_W'(BIT_CYCLES - 1);

  logic [CYC_W-1:0] cyc_cnt_r;
  logic [CYC_W-1:0] cyc_cnt_nxt_s;
  logic             bit_end_r;

  // Next cycle count: restart or wrap at the bit boundary, otherwise advance.
  always_comb begin
    cyc_cnt_nxt_s = cyc_cnt_r;
    if (restart) begin
      cyc_cnt_nxt_s = {CYC_W{1'b0}};
    end else if (cyc_cnt_r == CYC_LAST) begin
      cyc_cnt_nxt_s = {CYC_W{1'b0}};
    end else begin
      cyc_cnt_nxt_s = cyc_cnt_r + CYC_W'(1);
    end
  end

  // Count register; bit_end is registered by looking one cycle ahead.
  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      cyc_cnt_r <= {CYC_W{1'b0}};
      bit_end_r <= (BIT_CYCLES == 1) ? 1'b1 : 1'b0;
    end else begin
      cyc_cnt_r <= cyc_cnt_nxt_s;
      bit_end_r <= (cyc_cnt_nxt_s == CYC_LAST) ? 1'b1 : 1'b0;
    end
  end

  assign bit_end = bit_end_r;

endmodule

// File: rtl/gds_frame_tx.sv
// GDS serial transmitter: one code per handshake, framed as
// preamble | data MSB first | even parity | stop(0). Line idles low.
module gds_frame_tx
  import gds_pkg::*;
#(
  parameter int                DATA_W     = GDS_CODE_W,
  parameter int                PRE_W      = GDS_PRE_W,
  parameter logic [PRE_W-1:0]  PREAMBLE   = GDS_PREAMBLE,
  parameter int                BIT_CYCLES = 1
) (
  input  logic              clk,
  input  logic              arst_n,
  input  logic              tx_valid,
  input  logic [DATA_W-1:0] tx_data,
  output logic              tx_ready,
  output logic              gds_line,
  output logic              busy,
  output logic              done
);

  // Bits still queued after the first preamble bit: rest of preamble, data, parity, stop.
  localparam int FRAME_W = PRE_W + DATA_W + 1;
  localparam int CNT_MAX = ((PRE_W > DATA_W) ? PRE_W : DATA_W) - 1;
  localparam int CNT_W   = (CNT_MAX > 1) ? $clog2(CNT_MAX + 1) : 1;

  gds_state_e          state_r, state_nxt_s;
  logic [CNT_W-1:0]    bit_cnt_r, bit_cnt_nxt_s;
  logic [FRAME_W-1:0]  frame_r, frame_nxt_s;
  logic                line_r, line_nxt_s;
  logic                restart_s;
  logic                bit_end_s;

  gds_bit_timer #(
    .BIT_CYCLES (BIT_CYCLES)
  ) u_bit_timer (
    .clk     (clk),
    .arst_n  (arst_n),
    .restart (restart_s),
    .bit_end (bit_end_s)
  );

  // Next-state, bit counter, frame shifter and line value.
  always_comb begin
    state_nxt_s   = state_r;
    bit_cnt_nxt_s = bit_cnt_r;
    frame_nxt_s   = frame_r;
    line_nxt_s    = line_r;
    restart_s     = 1'b0;
    case (state_r)
      GDS_IDLE: begin
        line_nxt_s = 1'b0;
        if (tx_valid) begin
          state_nxt_s   = GDS_PRE;
          bit_cnt_nxt_s = {CNT_W{1'b0}};
          frame_nxt_s   = {PREAMBLE[PRE_W-2:0], tx_data,
                           even_parity(32'(tx_data)), 1'b0};
          line_nxt_s    = PREAMBLE[PRE_W-1];
          restart_s     = 1'b1;
        end else begin
          state_nxt_s = GDS_IDLE;
        end
      end
      GDS_PRE, GDS_DATA, GDS_PAR: begin
        if (bit_end_s) begin
          line_nxt_s  = frame_r[FRAME_W-1];
          frame_nxt_s = {frame_r[FRAME_W-2:0], 1'b0};
          if (state_r == GDS_PRE && bit_cnt_r == CNT_W'(PRE_W - 1)) begin
            state_nxt_s   = GDS_DATA;
            bit_cnt_nxt_s = {CNT_W{1'b0}};
          end else if (state_r == GDS_DATA && bit_cnt_r == CNT_W'(DATA_W - 1)) begin
            state_nxt_s   = GDS_PAR;
            bit_cnt_nxt_s = {CNT_W{1'b0}};
          end else if (state_r == GDS_PAR) begin
            state_nxt_s   = GDS_STOP;
            bit_cnt_nxt_s = {CNT_W{1'b0}};
          end else begin
            bit_cnt_nxt_s = bit_cnt_r + CNT_W'(1);
          end
        end else begin
          line_nxt_s = line_r;
        end
      end
      GDS_STOP: begin
        if (bit_end_s) begin
          state_nxt_s   = GDS_IDLE;
          bit_cnt_nxt_s = {CNT_W{1'b0}};
          line_nxt_s    = 1'b0;
        end else begin
          line_nxt_s = 1'b0;
        end
      end
      default: begin
        state_nxt_s   = GDS_IDLE;
        bit_cnt_nxt_s = {CNT_W{1'b0}};
        frame_nxt_s   = {FRAME_W{1'b0}};
        line_nxt_s    = 1'b0;
      end
    endcase
  end

  // State, counter, shift register and line register.
  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      state_r   <= GDS_IDLE;
      bit_cnt_r <= {CNT_W{1'b0}};
      frame_r   <= {FRAME_W{1'b0}};
      line_r    <= 1'b0;
    end else begin
      state_r   <= state_nxt_s;
      bit_cnt_r <= bit_cnt_nxt_s;
      frame_r   <= frame_nxt_s;
      line_r    <= line_nxt_s;
    end
  end

  assign gds_line = line_r;
  assign tx_ready = (state_r == GDS_IDLE);
  assign busy     = (state_r != GDS_IDLE);
  assign done     = (state_r == GDS_STOP) && bit_end_s;

endmodule
